// File: rtl/clock_run_step_controller.sv
// Derives the processor clock bus from ClockTick with run/halt/single-step control from two board pins.
// Optional CLKCTRL_CYCLE_COUNT_EN adds a 32-bit count of derived-clock rising edges.
module clock_run_step_controller #(
    parameter int HighTicks  = 1,
    parameter int LowTicks   = 1,
    parameter int NrOfBits   = 8,
    parameter int SyncStages = 2
) (
    input  logic        GlobalClock,
    input  logic        Reset,
    input  logic        ClockTick,
    input  logic        RunReq,
    input  logic        StepReq,
    output logic [4:0]  ClockBus,
    output logic        Running,
`ifdef CLKCTRL_CYCLE_COUNT_EN
    output logic        StepBusy,
    output logic [31:0] CycleCount
`else
    output logic        StepBusy
`endif
);
    localparam int SYNC_N = (SyncStages < 2) ? 2 : SyncStages;
    localparam logic [NrOfBits-1:0] HI_LOAD = (HighTicks <= 1) ? '0 : NrOfBits'(HighTicks - 1);
    localparam logic [NrOfBits-1:0] LO_LOAD = (LowTicks <= 1) ? '0 : NrOfBits'(LowTicks - 1);

    typedef enum logic [2:0] {HALT, RUN_LO, RUN_HI, STEP_HI, STEP_LO} state_t;

    state_t              r_state, w_state_nxt;
    logic [SYNC_N:0]     r_run_sync, r_step_sync;
    logic [NrOfBits-1:0] r_cnt, w_cnt_nxt;
    logic                r_clk, r_pos, r_neg, r_running, r_busy;
    logic                r_step_pend, r_pend_run, r_halt_pend;
    logic                w_clk_nxt, w_pos_nxt, w_neg_nxt;
    logic                w_step_pend_nxt, w_pend_run_nxt, w_halt_pend_nxt;
    logic                w_run_edge, w_step_edge, w_phase_end, w_run_toggled;

    // Top bit of each chain is the edge detector's previous sample.
    assign w_run_edge    = r_run_sync[SYNC_N-1] & ~r_run_sync[SYNC_N];
    assign w_step_edge   = r_step_sync[SYNC_N-1] & ~r_step_sync[SYNC_N];
    assign w_phase_end   = ClockTick && (r_cnt == '0);
    assign w_run_toggled = r_pend_run ^ w_run_edge;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = (ClockTick && r_cnt != '0) ? r_cnt - NrOfBits'(1) : r_cnt;
        w_clk_nxt       = r_clk;
        w_pos_nxt       = 1'b0;
        w_neg_nxt       = 1'b0;
        w_step_pend_nxt = r_step_pend;
        w_pend_run_nxt  = r_pend_run;
        w_halt_pend_nxt = r_halt_pend;
        case (r_state)
            HALT: begin
                w_clk_nxt = 1'b0;
                if (w_run_edge) begin
                    w_state_nxt     = RUN_LO;
                    w_cnt_nxt       = LO_LOAD;
                    w_step_pend_nxt = 1'b0;
                end else if ((r_step_pend || w_step_edge) && ClockTick) begin
                    w_state_nxt     = STEP_HI;
                    w_cnt_nxt       = HI_LOAD;
                    w_clk_nxt       = 1'b1;
                    w_pos_nxt       = 1'b1;
                    w_step_pend_nxt = 1'b0;
                end else if (w_step_edge) begin
                    w_step_pend_nxt = 1'b1;
                end
            end
            RUN_LO: begin
                // Clock is already low here, so halting at once cannot glitch it.
                if (w_run_edge) begin
                    w_state_nxt = HALT;
                end else if (w_phase_end) begin
                    w_state_nxt = RUN_HI;
                    w_cnt_nxt   = HI_LOAD;
                    w_clk_nxt   = 1'b1;
                    w_pos_nxt   = 1'b1;
                end
            end
            RUN_HI: begin
                if (w_run_edge) w_halt_pend_nxt = 1'b1;
                if (w_phase_end) begin
                    w_clk_nxt       = 1'b0;
                    w_neg_nxt       = 1'b1;
                    w_halt_pend_nxt = 1'b0;
                    if (r_halt_pend || w_run_edge) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_state_nxt = RUN_LO;
                        w_cnt_nxt   = LO_LOAD;
                    end
                end
            end
            STEP_HI: begin
                w_pend_run_nxt = w_run_toggled;
                if (w_phase_end) begin
                    w_state_nxt = STEP_LO;
                    w_clk_nxt   = 1'b0;
                    w_neg_nxt   = 1'b1;
                end
            end
            STEP_LO: begin
                w_pend_run_nxt = 1'b0;
                if (w_run_toggled) begin
                    w_state_nxt = RUN_LO;
                    w_cnt_nxt   = LO_LOAD;
                end else begin
                    w_state_nxt = HALT;
                end
            end
            default: begin
                w_state_nxt = HALT;
                w_clk_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge GlobalClock) begin
        if (Reset) begin
            r_state     <= HALT;
            r_run_sync  <= '0;
            r_step_sync <= '0;
            r_cnt       <= '0;
            r_clk       <= 1'b0;
            r_pos       <= 1'b0;
            r_neg       <= 1'b0;
            r_running   <= 1'b0;
            r_busy      <= 1'b0;
            r_step_pend <= 1'b0;
            r_pend_run  <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_run_sync  <= {r_run_sync[SYNC_N-1:0], RunReq};
            r_step_sync <= {r_step_sync[SYNC_N-1:0], StepReq};
            r_cnt       <= w_cnt_nxt;
            r_clk       <= w_clk_nxt;
            r_pos       <= w_pos_nxt;
            r_neg       <= w_neg_nxt;
            r_running   <= (w_state_nxt == RUN_LO) || (w_state_nxt == RUN_HI);
            r_busy      <= (w_state_nxt == STEP_HI) || (w_state_nxt == STEP_LO);
            r_step_pend <= w_step_pend_nxt;
            r_pend_run  <= w_pend_run_nxt;
            r_halt_pend <= w_halt_pend_nxt;
        end
    end

`ifdef CLKCTRL_CYCLE_COUNT_EN
    logic [31:0] r_cycles;
    always_ff @(posedge GlobalClock) begin
        if (Reset)          r_cycles <= '0;
        else if (w_pos_nxt) r_cycles <= r_cycles + 32'd1;
    end
    assign CycleCount = r_cycles;
`endif

    assign ClockBus = {GlobalClock, r_neg, r_pos, ~r_clk, r_clk};
    assign Running  = r_running;
    assign StepBusy = r_busy;
endmodule

// File: tb/tb_clock_run_step_controller.sv
// Directed bench for clock_run_step_controller: HighTicks=3, LowTicks=2, SyncStages=2, ClockTick every 4 cycles.
module tb_clock_run_step_controller;
    logic       GlobalClock = 1'b0;
    logic       Reset = 1'b1;
    logic       ClockTick = 1'b0;
    logic       RunReq = 1'b0;
    logic       StepReq = 1'b0;
    logic [4:0] ClockBus;
    logic       Running;
    logic       StepBusy;
`ifdef CLKCTRL_CYCLE_COUNT_EN
    logic [31:0] CycleCount;
`endif

    int checks = 0, errors = 0;
    int tphase = 0, ncyc = 0;
    int pos_cnt, neg_cnt, hi_cyc, busy_cnt, run_cnt, first_pos, first_neg, first_run;
    int inv_err = 0, pulse_err = 0;
    logic prev_clk = 1'b0;

    always #5 GlobalClock = ~GlobalClock;

    clock_run_step_controller #(.HighTicks(3), .LowTicks(2), .NrOfBits(8), .SyncStages(2)) dut (
        .GlobalClock(GlobalClock),
        .Reset(Reset),
        .ClockTick(ClockTick),
        .RunReq(RunReq),
        .StepReq(StepReq),
        .ClockBus(ClockBus),
        .Running(Running),
`ifdef CLKCTRL_CYCLE_COUNT_EN
        .StepBusy(StepBusy),
        .CycleCount(CycleCount)
`else
        .StepBusy(StepBusy)
`endif
    );

    // One GlobalClock cycle; ClockTick is high on every fourth cycle. Outputs sampled 1 time unit after the edge.
    task automatic cyc();
        ClockTick = (tphase == 0);
        @(posedge GlobalClock);
        #1;
        tphase = (tphase + 1) % 4;
        ncyc++;
        if (ClockBus[2]) begin pos_cnt++; if (first_pos < 0) first_pos = ncyc; end
        if (ClockBus[3]) begin neg_cnt++; if (first_neg < 0) first_neg = ncyc; end
        if (Running && first_run < 0) first_run = ncyc;
        hi_cyc   += int'(ClockBus[0]);
        busy_cnt += int'(StepBusy);
        run_cnt  += int'(Running);
        if (ClockBus[1] !== ~ClockBus[0]) inv_err++;
        if (ClockBus[2] && !(ClockBus[0] && !prev_clk)) pulse_err++;
        if (ClockBus[3] && !(!ClockBus[0] && prev_clk)) pulse_err++;
        prev_clk = ClockBus[0];
    endtask

    task automatic clr();
        ncyc = 0; pos_cnt = 0; neg_cnt = 0; hi_cyc = 0; busy_cnt = 0; run_cnt = 0;
        first_pos = -1; first_neg = -1; first_run = -1;
    endtask

    task automatic align();
        while (tphase != 0) cyc();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) cyc();
        checks++; if (ClockBus[3:0] !== 4'b0010) begin errors++; $display("FAIL reset_bus got %b exp 0010", ClockBus[3:0]); end
        checks++; if (Running !== 1'b0 || StepBusy !== 1'b0) begin errors++; $display("FAIL reset_flags got run=%b busy=%b exp 0 0", Running, StepBusy); end
        checks++; if (ClockBus[4] !== 1'b1) begin errors++; $display("FAIL passthru_hi got %b exp 1", ClockBus[4]); end
        @(negedge GlobalClock); #1;
        checks++; if (ClockBus[4] !== 1'b0) begin errors++; $display("FAIL passthru_lo got %b exp 0", ClockBus[4]); end
        Reset = 1'b0;
        clr();
        repeat (400) cyc();
        checks++; if (pos_cnt + neg_cnt + hi_cyc + run_cnt + busy_cnt !== 0) begin errors++; $display("FAIL idle_activity got %0d exp 0", pos_cnt + neg_cnt + hi_cyc + run_cnt + busy_cnt); end
        checks++; if (ClockBus[3:0] !== 4'b0010) begin errors++; $display("FAIL idle_bus got %b exp 0010", ClockBus[3:0]); end
`ifdef CLKCTRL_CYCLE_COUNT_EN
        checks++; if (CycleCount !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", CycleCount); end
`endif
    endtask

    task automatic test_step();
        align(); clr();
        StepReq = 1'b1;
        repeat (6) cyc();
        StepReq = 1'b0;
        repeat (34) cyc();
        checks++; if (first_pos !== 5) begin errors++; $display("FAIL step_rise_cycle got %0d exp 5", first_pos); end
        checks++; if (first_neg !== 17) begin errors++; $display("FAIL step_fall_cycle got %0d exp 17", first_neg); end
        checks++; if (pos_cnt !== 1 || neg_cnt !== 1) begin errors++; $display("FAIL step_pulses got pos=%0d neg=%0d exp 1 1", pos_cnt, neg_cnt); end
        checks++; if (hi_cyc !== 12) begin errors++; $display("FAIL step_high_len got %0d exp 12", hi_cyc); end
        checks++; if (busy_cnt !== 13) begin errors++; $display("FAIL step_busy_len got %0d exp 13", busy_cnt); end
        checks++; if (run_cnt !== 0 || StepBusy !== 1'b0 || ClockBus[0] !== 1'b0) begin errors++; $display("FAIL step_end got run=%0d busy=%b clk=%b exp 0 0 0", run_cnt, StepBusy, ClockBus[0]); end
`ifdef CLKCTRL_CYCLE_COUNT_EN
        checks++; if (CycleCount !== 32'd1) begin errors++; $display("FAIL step_count got %0d exp 1", CycleCount); end
`endif
    endtask

    task automatic test_run();
        align(); clr();
        RunReq = 1'b1;
        repeat (44) cyc();
        RunReq = 1'b0;
        checks++; if (first_run !== 3) begin errors++; $display("FAIL run_latency got %0d exp 3", first_run); end
        checks++; if (first_pos !== 9 || first_neg !== 21) begin errors++; $display("FAIL run_edges got pos=%0d neg=%0d exp 9 21", first_pos, first_neg); end
        checks++; if (pos_cnt !== 2 || neg_cnt !== 2) begin errors++; $display("FAIL run_pulses got pos=%0d neg=%0d exp 2 2", pos_cnt, neg_cnt); end
        checks++; if (hi_cyc !== 24 || run_cnt !== 42) begin errors++; $display("FAIL run_duty got hi=%0d run=%0d exp 24 42", hi_cyc, run_cnt); end
`ifdef CLKCTRL_CYCLE_COUNT_EN
        checks++; if (CycleCount !== 32'd3) begin errors++; $display("FAIL run_count got %0d exp 3", CycleCount); end
`endif
    endtask

    task automatic test_halt_pending();
        logic found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc();
            if (ClockBus[2]) found = 1'b1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL halt_wait_rise got %b exp 1", found); end
        clr();
        repeat (4) cyc();
        RunReq = 1'b1;
        repeat (16) cyc();
        RunReq = 1'b0;
        checks++; if (first_neg !== 12 || neg_cnt !== 1) begin errors++; $display("FAIL halt_fall got cyc=%0d n=%0d exp 12 1", first_neg, neg_cnt); end
        checks++; if (hi_cyc !== 11 || run_cnt !== 11) begin errors++; $display("FAIL halt_high got hi=%0d run=%0d exp 11 11", hi_cyc, run_cnt); end
        checks++; if (pos_cnt !== 0 || Running !== 1'b0) begin errors++; $display("FAIL halt_final got pos=%0d run=%b exp 0 0", pos_cnt, Running); end
    endtask

    task automatic test_halt_in_low();
        repeat (4) cyc();
        align(); clr();
        RunReq = 1'b1;
        repeat (4) cyc();
        RunReq = 1'b0;
        repeat (2) cyc();
        RunReq = 1'b1;
        repeat (14) cyc();
        RunReq = 1'b0;
        checks++; if (first_run !== 3 || run_cnt !== 6) begin errors++; $display("FAIL low_halt_run got first=%0d n=%0d exp 3 6", first_run, run_cnt); end
        checks++; if (pos_cnt !== 0 || hi_cyc !== 0 || Running !== 1'b0) begin errors++; $display("FAIL low_halt_clk got pos=%0d hi=%0d run=%b exp 0 0 0", pos_cnt, hi_cyc, Running); end
    endtask

    task automatic test_run_step_same();
        repeat (4) cyc();
        align(); clr();
        RunReq = 1'b1; StepReq = 1'b1;
        repeat (4) cyc();
        RunReq = 1'b0; StepReq = 1'b0;
        repeat (8) cyc();
        checks++; if (first_run !== 3 || busy_cnt !== 0) begin errors++; $display("FAIL same_run_wins got run=%0d busy=%0d exp 3 0", first_run, busy_cnt); end
        checks++; if (first_pos !== 9 || ClockBus[0] !== 1'b1 || Running !== 1'b1) begin errors++; $display("FAIL same_rise got pos=%0d clk=%b run=%b exp 9 1 1", first_pos, ClockBus[0], Running); end
    endtask

    task automatic test_reset_mid_run();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        checks++; if (ClockBus[3:0] !== 4'b0010 || neg_cnt !== 0) begin errors++; $display("FAIL midrst_bus got %b neg=%0d exp 0010 0", ClockBus[3:0], neg_cnt); end
        checks++; if (Running !== 1'b0 || StepBusy !== 1'b0) begin errors++; $display("FAIL midrst_flags got run=%b busy=%b exp 0 0", Running, StepBusy); end
`ifdef CLKCTRL_CYCLE_COUNT_EN
        checks++; if (CycleCount !== 32'd0) begin errors++; $display("FAIL midrst_count got %0d exp 0", CycleCount); end
`endif
        clr();
        repeat (20) cyc();
        checks++; if (pos_cnt !== 0 || run_cnt !== 0) begin errors++; $display("FAIL midrst_halt got pos=%0d run=%0d exp 0 0", pos_cnt, run_cnt); end
    endtask

    task automatic test_step_then_run();
        align(); clr();
        StepReq = 1'b1;
        repeat (6) cyc();
        StepReq = 1'b0; RunReq = 1'b1;
        repeat (20) cyc();
        RunReq = 1'b0;
        checks++; if (first_pos !== 5 || first_neg !== 17) begin errors++; $display("FAIL steprun_step got pos=%0d neg=%0d exp 5 17", first_pos, first_neg); end
        checks++; if (first_run !== 18 || busy_cnt !== 13) begin errors++; $display("FAIL steprun_handoff got run=%0d busy=%0d exp 18 13", first_run, busy_cnt); end
        checks++; if (pos_cnt !== 2 || Running !== 1'b1) begin errors++; $display("FAIL steprun_rise got pos=%0d run=%b exp 2 1", pos_cnt, Running); end
    endtask

    task automatic test_invariants();
        checks++; if (inv_err !== 0) begin errors++; $display("FAIL inverse_bit got %0d bad cycles exp 0", inv_err); end
        checks++; if (pulse_err !== 0) begin errors++; $display("FAIL edge_pulses got %0d bad cycles exp 0", pulse_err); end
    endtask

    initial begin
        clr();
        test_reset();
        test_step();
        test_run();
        test_halt_pending();
        test_halt_in_low();
        test_run_step_same();
        test_reset_mid_run();
        test_step_then_run();
        test_invariants();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
